// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_arb_pkg
//  Description : Shared constants and types for the two-requester APB master
//                arbiter: bus widths, requester count, FSM state encoding,
//                the latched request record and a one-hot helper.
//  Revision    : 1.0  initial release
// ============================================================================
package apb_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int NREQ   = 2;

  // APB master FSM encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  // Request fields captured at grant time and driven onto the bus
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

  // Requester index -> one-hot requester vector
  function automatic logic [NREQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage : apb_arb_pkg
`default_nettype wire

// File: rtl/apb_gpio_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter. A lone requester wins outright;
//                on a tie the requester that was not granted last wins. The
//                pointer only moves when a grant is actually issued.
//  Ports       : clk      - clock
//                rst      - synchronous active-high reset (requester 0 wins
//                           the first tie afterwards)
//                i_en     - arbitration enable (grant suppressed when low)
//                i_req    - request vector, bit i = requester i
//                o_grant  - one-hot grant (combinational)
//                o_idx    - index of the granted requester
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import apb_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic            o_idx
);

  // Index of the requester granted most recently. Resetting it to 1 makes
  // requester 0 the winner of the first tie.
  logic r_last;

  always_comb begin
    o_grant = '0;
    o_idx   = 1'b0;
    if (i_en) begin
      case (i_req)
        2'b01:   o_idx = 1'b0;
        2'b10:   o_idx = 1'b1;
        2'b11:   o_idx = ~r_last;
        default: o_idx = 1'b0;
      endcase
      if (|i_req) begin
        o_grant = req_onehot(o_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_en && (|i_req)) begin
      r_last <= o_idx;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/apb_gpio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_gpio_arbiter
//  Description : Arbitrates two simple request/response clients onto a single
//                APB master port (IDLE -> SETUP -> ACCESS). Grants are issued
//                combinationally in IDLE, the winning request is latched and
//                replayed on APB, and a one-cycle registered response pulse
//                returns read data to the owner.
//  Build macro : APB_ARB_TIMEOUT_EN - when defined, an ACCESS phase that sees
//                PREADY=0 for TIMEOUT_CYCLES cycles is aborted and answered
//                with rsp_err=1, rsp_rdata=0. Undefined: ACCESS waits forever
//                and rsp_err is tied low.
//  Ports       : PCLK, PRESET            - clock, sync active-high reset
//                req_valid/req_write     - per-requester request, direction
//                req_addr/req_wdata      - packed [8i+7:8i] per requester
//                req_grant               - one-hot acceptance pulse (IDLE)
//                rsp_valid/rsp_rdata     - one-hot completion pulse, data
//                rsp_err                 - timeout flag
//                PSEL/PENABLE/PWRITE/PADDR/PWDATA - APB master outputs
//                PRDATA/PREADY           - APB slave response
//  Revision    : 1.0  initial release
// ============================================================================
module apb_gpio_arbiter
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_grant,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic [DATA_W-1:0]      PRDATA,
  input  logic                   PREADY
);

  logic [1:0]        r_state;
  apb_req_t          r_req;
  logic              r_owner;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_arb_en;
  logic [NREQ-1:0]   w_grant;
  logic              w_idx;
  apb_req_t          w_sel_req;

  // Grants only in IDLE and never while reset is asserted
  assign w_arb_en = (r_state == IDLE) && !PRESET;

  rr_arbiter2 u_rr_arbiter2 (
    .clk     (PCLK),
    .rst     (PRESET),
    .i_en    (w_arb_en),
    .i_req   (req_valid),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Fields of the winning requester, selected from the packed buses
  always_comb begin
    w_sel_req       = '0;
    w_sel_req.write = req_write[w_idx];
    w_sel_req.addr  = w_idx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    w_sel_req.wdata = w_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  assign req_grant = w_grant;
  assign PSEL      = (r_state != IDLE);
  assign PENABLE   = (r_state == ACCESS);
  assign PWRITE    = r_req.write;
  assign PADDR     = r_req.addr;
  assign PWDATA    = r_req.wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_tmo_cnt;
  logic               r_rsp_err;
  logic               w_timeout;

  // Fires on the ACCESS wait cycle that brings the count to TIMEOUT_CYCLES;
  // a simultaneous PREADY wins because completion is tested first below.
  assign w_timeout = (r_state == ACCESS) && !PREADY && (r_tmo_cnt == c_CNT_LAST);
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_tmo_cnt <= '0;
      r_rsp_err <= 1'b0;
    end else if (r_state == ACCESS) begin
      if (PREADY) begin
        r_tmo_cnt <= '0;
        r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
        r_tmo_cnt <= '0;
        r_rsp_err <= 1'b1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  logic w_timeout;

  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_owner     <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_req   <= w_sel_req;
            r_owner <= w_idx;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            r_rsp_valid <= req_onehot(r_owner);
            r_rsp_rdata <= r_req.write ? '0 : PRDATA;
            r_state     <= IDLE;
          end else if (w_timeout) begin
            r_rsp_valid <= req_onehot(r_owner);
            r_rsp_rdata <= '0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : apb_gpio_arbiter
`default_nettype wire
